// File: rtl/branch_pc_unit_if.sv
// Bus between the decode/flag stage (master) and the PC/branch-resolution unit (slave).
// Adds the branch statistics counters when BRANCH_STATS_EN is defined.
interface branch_pc_unit_if #(parameter int n = 32);
  logic         stall;
  logic         br_en;
  logic         jal;
  logic         jalr;
  logic [2:0]   funct3;
  logic         flag_eq;
  logic         flag_ge;
  logic [n-1:0] imm;
  logic [n-1:0] rs1;
  logic         trap_ack;
  logic [n-1:0] pc;
  logic [n-1:0] pc_plus4;
  logic         pc_valid;
  logic         flush;
  logic         misalign_trap;
`ifdef BRANCH_STATS_EN
  logic [31:0]  br_taken_cnt;
  logic [31:0]  br_total_cnt;
`endif

  modport master (
    output stall, br_en, jal, jalr, funct3, flag_eq, flag_ge, imm, rs1, trap_ack,
`ifdef BRANCH_STATS_EN
    input  br_taken_cnt, br_total_cnt,
`endif
    input  pc, pc_plus4, pc_valid, flush, misalign_trap
  );

  modport slave (
    input  stall, br_en, jal, jalr, funct3, flag_eq, flag_ge, imm, rs1, trap_ack,
`ifdef BRANCH_STATS_EN
    output br_taken_cnt, br_total_cnt,
`endif
    output pc, pc_plus4, pc_valid, flush, misalign_trap
  );
endinterface

// File: rtl/branch_pc_unit.sv
// PC register and branch resolution with one-cycle flush and misaligned-target trap FSM.
// Optional BRANCH_STATS_EN adds saturating branch taken/total counters.
module branch_pc_unit #(
  parameter int           n         = 32,
  parameter logic [n-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [n-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            n_reset,
  branch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_TRAP} state_t;

  localparam logic [n-1:0] FOUR = n'(4);

  state_t       state_q;
  logic [n-1:0] pc_q;
  logic         valid_q;
  logic         flush_q;
  logic         trap_q;

  logic         cond_met;
  logic         taken;
  logic         misaligned;
  logic [n-1:0] jalr_sum;
  logic [n-1:0] target;

  always_comb begin
    cond_met = 1'b0;
    case (bus.funct3)
      3'b000:          cond_met = bus.flag_eq;
      3'b001:          cond_met = !bus.flag_eq;
      3'b100, 3'b110:  cond_met = !bus.flag_ge;
      3'b101, 3'b111:  cond_met = bus.flag_ge;
      default:         cond_met = 1'b0;
    endcase
  end

  assign taken      = bus.jalr || bus.jal || (bus.br_en && cond_met);
  assign jalr_sum   = bus.rs1 + bus.imm;
  assign target     = bus.jalr ? {jalr_sum[n-1:1], 1'b0} : (pc_q + bus.imm);
  assign misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_RUN;
          valid_q <= 1'b1;
          flush_q <= 1'b0;
        end
        S_RUN: begin
          flush_q <= 1'b0;
          if (!bus.stall) begin
            if (taken && misaligned) begin
              state_q <= S_TRAP;
              trap_q  <= 1'b1;
              valid_q <= 1'b0;
            end else if (taken) begin
              pc_q    <= target;
              flush_q <= 1'b1;
            end else begin
              pc_q    <= pc_q + FOUR;
            end
          end
        end
        S_TRAP: begin
          flush_q <= 1'b0;
          if (bus.trap_ack) begin
            state_q <= S_RUN;
            pc_q    <= TRAP_VEC;
            flush_q <= 1'b1;
            trap_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_BOOT;
          valid_q <= 1'b0;
          flush_q <= 1'b0;
          trap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_q + FOUR;
  assign bus.pc_valid      = valid_q;
  assign bus.flush         = flush_q;
  assign bus.misalign_trap = trap_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] total_cnt_q;
  logic        count_br;

  // Only pure conditional branches count; a jump decoded alongside br_en wins and is skipped.
  assign count_br = (state_q == S_RUN) && !bus.stall && bus.br_en && !bus.jal && !bus.jalr;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      taken_cnt_q <= 32'd0;
      total_cnt_q <= 32'd0;
    end else if (count_br) begin
      if (total_cnt_q != 32'hFFFF_FFFF) total_cnt_q <= total_cnt_q + 32'd1;
      if (cond_met && (taken_cnt_q != 32'hFFFF_FFFF)) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign bus.br_taken_cnt = taken_cnt_q;
  assign bus.br_total_cnt = total_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed test of branch_pc_unit: boot, branch conditions, stall, JALR/JAL, trap, wrap.
// Counter checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_pc_unit;
  logic clk;
  logic n_reset;
  int   compared;
  int   mismatched;

  branch_pc_unit_if #(.n(32)) bus();

  branch_pc_unit dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall    = 1'b0;
    bus.br_en    = 1'b0;
    bus.jal      = 1'b0;
    bus.jalr     = 1'b0;
    bus.funct3   = 3'b000;
    bus.flag_eq  = 1'b0;
    bus.flag_ge  = 1'b0;
    bus.imm      = 32'h0;
    bus.rs1      = 32'h0;
    bus.trap_ack = 1'b0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic eq, input logic ge, input logic [31:0] off);
    idle_inputs();
    bus.br_en   = 1'b1;
    bus.funct3  = f3;
    bus.flag_eq = eq;
    bus.flag_ge = ge;
    bus.imm     = off;
  endtask

  task automatic do_jal(input logic [31:0] off);
    idle_inputs();
    bus.jal = 1'b1;
    bus.imm = off;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    n_reset    = 1'b0;
    idle_inputs();

    #12;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
    check("rst_flush", {31'b0, bus.flush}, 32'h0);
    check("rst_trap", {31'b0, bus.misalign_trap}, 32'h0);
    n_reset = 1'b1;
    #1;
    check("boot_valid", {31'b0, bus.pc_valid}, 32'h0);

    tick();
    check("run_pc", bus.pc, 32'h0);
    check("run_valid", {31'b0, bus.pc_valid}, 32'h1);
    tick();
    check("seq_pc", bus.pc, 32'h4);
    check("seq_plus4", bus.pc_plus4, 32'h8);

    do_jal(32'h3C);
    tick();
    check("jal_pc", bus.pc, 32'h40);
    check("jal_flush", {31'b0, bus.flush}, 32'h1);

    branch(3'b000, 1'b1, 1'b0, 32'h20);
    tick();
    check("beq_t_pc", bus.pc, 32'h60);
    check("beq_t_flush", {31'b0, bus.flush}, 32'h1);
    idle_inputs();
    tick();
    check("seq2_pc", bus.pc, 32'h64);
    check("flush_once", {31'b0, bus.flush}, 32'h0);

    do_jal(32'hFFFF_FFDC);
    tick();
    check("jal_back_pc", bus.pc, 32'h40);
    branch(3'b000, 1'b0, 1'b0, 32'h20);
    tick();
    check("beq_nt_pc", bus.pc, 32'h44);
    check("beq_nt_flush", {31'b0, bus.flush}, 32'h0);

    branch(3'b001, 1'b0, 1'b0, 32'h3C);
    tick();
    check("bne_t_pc", bus.pc, 32'h80);

    branch(3'b101, 1'b0, 1'b1, 32'hFFFF_FFF8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc, 32'h80);
      check("stall_flush", {31'b0, bus.flush}, 32'h0);
    end
    bus.stall = 1'b0;
    tick();
    check("bge_t_pc", bus.pc, 32'h78);
    check("bge_t_flush", {31'b0, bus.flush}, 32'h1);

    branch(3'b010, 1'b1, 1'b1, 32'h100);
    tick();
    check("f3_010_pc", bus.pc, 32'h7C);
    branch(3'b100, 1'b0, 1'b1, 32'h100);
    tick();
    check("blt_nt_pc", bus.pc, 32'h80);

`ifdef BRANCH_STATS_EN
    check("cnt_total_a", bus.br_total_cnt, 32'd6);
    check("cnt_taken_a", bus.br_taken_cnt, 32'd3);
`endif

    idle_inputs();
    bus.jalr = 1'b1;
    bus.jal  = 1'b1;
    bus.rs1  = 32'h1001;
    bus.imm  = 32'h0;
    tick();
    check("jalr_pc", bus.pc, 32'h1000);
    check("jalr_flush", {31'b0, bus.flush}, 32'h1);

    do_jal(32'h6);
    tick();
    check("mis_trap", {31'b0, bus.misalign_trap}, 32'h1);
    check("mis_pc", bus.pc, 32'h1000);
    check("mis_valid", {31'b0, bus.pc_valid}, 32'h0);
    check("mis_flush", {31'b0, bus.flush}, 32'h0);
    idle_inputs();
    bus.stall = 1'b1;
    tick();
    check("trap_hold", {31'b0, bus.misalign_trap}, 32'h1);
    check("trap_hold_pc", bus.pc, 32'h1000);
    bus.trap_ack = 1'b1;
    tick();
    check("ack_pc", bus.pc, 32'h100);
    check("ack_flush", {31'b0, bus.flush}, 32'h1);
    check("ack_trap", {31'b0, bus.misalign_trap}, 32'h0);
    check("ack_valid", {31'b0, bus.pc_valid}, 32'h1);

    do_jal(32'hFFFF_FEFC);
    tick();
    check("top_pc", bus.pc, 32'hFFFF_FFFC);
    check("top_plus4", bus.pc_plus4, 32'h0);
    idle_inputs();
    tick();
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_plus4", bus.pc_plus4, 32'h4);

    do_jal(32'h2);
    tick();
    check("mis2_trap", {31'b0, bus.misalign_trap}, 32'h1);
    idle_inputs();
    n_reset = 1'b0;
    #2;
    check("mid_rst_pc", bus.pc, 32'h0);
    check("mid_rst_trap", {31'b0, bus.misalign_trap}, 32'h0);
    check("mid_rst_valid", {31'b0, bus.pc_valid}, 32'h0);
`ifdef BRANCH_STATS_EN
    check("rst_total", bus.br_total_cnt, 32'd0);
    check("rst_taken", bus.br_taken_cnt, 32'd0);
`endif
    n_reset = 1'b1;
    tick();
    check("reboot_valid", {31'b0, bus.pc_valid}, 32'h1);

    branch(3'b000, 1'b1, 1'b0, 32'h8);
    tick();
    branch(3'b000, 1'b0, 1'b0, 32'h8);
    tick();
    branch(3'b111, 1'b0, 1'b1, 32'h4);
    tick();
    branch(3'b110, 1'b0, 1'b1, 32'h40);
    tick();
    branch(3'b001, 1'b0, 1'b0, 32'hC);
    tick();
    check("five_br_pc", bus.pc, 32'h20);
`ifdef BRANCH_STATS_EN
    check("cnt_total_b", bus.br_total_cnt, 32'd5);
    check("cnt_taken_b", bus.br_taken_cnt, 32'd3);
`endif
    idle_inputs();
    tick();
    check("final_pc", bus.pc, 32'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter / branch-resolution stage directly downstream of the branch flag generator.
- Consumes the flag generator's equality and greater-or-equal flags plus the decoded branch/jump controls, decides taken/not-taken, and computes the target.
- Holds the architectural PC, issues a one-cycle flush on redirect, and traps misaligned targets through a small state machine.

Parameters:
- n, 32, datapath/PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a misalign trap is acknowledged.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- stall  input  1  freezes PC and state when high.
- br_en  input  1  current instruction is a conditional branch.
- jal  input  1  current instruction is JAL.
- jalr  input  1  current instruction is JALR.
- funct3  input  3  branch condition code.
- flag_eq  input  1  operands equal; from the flag generator.
- flag_ge  input  1  A>=B; from the flag generator, signed/unsigned as selected upstream by funct3[1].
- imm  input  n  sign-extended offset.
- rs1  input  n  JALR base register value.
- trap_ack  input  1  trap handler accepted the misalign trap.
- pc  output  n  current PC.
- pc_plus4  output  n  pc+4, for link writeback.
- pc_valid  output  1  pc is a fetchable address.
- flush  output  1  one-cycle pulse on a taken redirect.
- misalign_trap  output  1  held high while in TRAP.

Behaviour:
- Reset (n_reset low, asynchronous): pc=RESET_VEC, state=BOOT, pc_valid=0, flush=0, misalign_trap=0. Reset mid-operation aborts everything, including TRAP.
- States:
  - BOOT: lasts exactly one clk after reset release. pc holds RESET_VEC. Then goes to RUN with pc_valid=1. Stall is ignored in BOOT.
  - RUN:
    - stall=1: pc, state and all inputs ignored; flush=0. A branch coinciding with stall is evaluated in the first non-stall cycle; upstream holds its inputs.
    - Otherwise, compute taken:
      - jal or jalr: always taken. jalr has priority over jal; jal has priority over br_en.
      - br_en with funct3 000 (BEQ): taken = flag_eq.
      - 001 (BNE): taken = !flag_eq.
      - 100/110 (BLT/BLTU): taken = !flag_ge.
      - 101/111 (BGE/BGEU): taken = flag_ge.
      - 010/011: not taken.
    - Target:
      - branch/JAL: pc+imm, modulo 2^n (wrap, no overflow flag).
      - JALR: (rs1+imm) with bit0 cleared.
    - Taken and target[1:0]==00: next pc=target, flush=1 for one cycle.
    - Taken and target[1]==1 (misaligned): pc holds, flush=0, next state TRAP.
    - Not taken: pc = pc+4 (wraps at 2^n), flush=0.
  - TRAP:
    - misalign_trap=1, pc_valid=0, pc frozen. stall is ignored.
    - On trap_ack=1: pc=TRAP_VEC, flush=1, state=RUN, misalign_trap=0 and pc_valid=1 on the next cycle.
- pc_plus4 = pc+4, combinational, modulo 2^n.
- Latency: the decision is registered; the new pc is visible the cycle after a non-stalled evaluation.
- All outputs are registered except pc_plus4.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs br_taken_cnt[31:0] and br_total_cnt[31:0].
  - br_total_cnt increments on every non-stalled RUN cycle with br_en=1.
  - br_taken_cnt increments when such a branch is taken.
  - Jumps are not counted; misaligned taken branches are counted.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then release -> pc=0, pc_valid=0 for 1 cycle; then pc=0 with pc_valid=1. Next cycle pc=4, with br_en=0.
- pc=0x40, br_en=1, funct3=000, flag_eq=1, imm=0x20 -> pc=0x60, flush pulses once. Same inputs with flag_eq=0 -> pc=0x44, flush=0.
- pc=0x80, funct3=101, flag_ge=1, imm=-8, with stall=1 for 3 cycles then 0 -> pc holds 0x80 for 3 cycles, then pc=0x78.
- jalr=1, rs1=0x1001, imm=0x0 -> pc=0x1000. Then jal=1, imm=0x6 -> misalign_trap=1, pc holds 0x1000. trap_ack=1 -> pc=0x100, flush=1, misalign_trap=0.
- pc=0xFFFF_FFFC, no branch -> pc wraps to 0x0, pc_plus4 = 0x4.
- With BRANCH_STATS_EN: 5 branches with 3 taken -> br_total_cnt=5, br_taken_cnt=3. Assert n_reset mid-run -> both counters return to 0 and pc=RESET_VEC.
